// File: rtl/jt51_kon_wr.sv
// rtl/jt51_kon_wr.sv - key-on register write decoder with one-deep request buffer
// Holds each key-on request for a full slot revolution; a second request may be queued.
module jt51_kon_wr #(
  parameter logic [7:0] KON_ADDR = 8'h08,
  parameter int         SLOTS    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       reg_wr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_din,
  output logic       up_keyon,
  output logic [2:0] keyon_ch,
  output logic [3:0] keyon_op,
  output logic       kon_busy,
  output logic       kon_ovf
);

  localparam int CW = $clog2(SLOTS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    ch, ch_nx, pch, pch_nx;
  logic [3:0]    op, op_nx, pop, pop_nx;
  logic          pv, pv_nx;
  logic          busy, busy_nx;
  logic          ovf, ovf_nx;
  logic          acc, done;
  logic          unused_din;

  assign unused_din = reg_din[7];
  assign acc  = reg_wr && (reg_addr == KON_ADDR);
  assign done = (state == ACTIVE) && cen && (cnt == CW'(SLOTS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ch    <= '0;
      op    <= '0;
      pv    <= 1'b0;
      pch   <= '0;
      pop   <= '0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ch    <= ch_nx;
      op    <= op_nx;
      pv    <= pv_nx;
      pch   <= pch_nx;
      pop   <= pop_nx;
      busy  <= busy_nx;
      ovf   <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ch_nx    = ch;
    op_nx    = op;
    pv_nx    = pv;
    pch_nx   = pch;
    pop_nx   = pop;
    ovf_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          state_nx = ACTIVE;
          cnt_nx   = '0;
          ch_nx    = reg_din[2:0];
          op_nx    = reg_din[6:3];
        end
      end
      ACTIVE: begin
        if (done) begin
          cnt_nx = '0;
          if (pv) begin
            // pending goes first; a same-edge write refills the buffer behind it
            ch_nx  = pch;
            op_nx  = pop;
            pv_nx  = acc;
            if (acc) begin
              pch_nx = reg_din[2:0];
              pop_nx = reg_din[6:3];
            end
          end else if (acc) begin
            ch_nx = reg_din[2:0];
            op_nx = reg_din[6:3];
          end else begin
            state_nx = IDLE;
          end
        end else begin
          if (cen)
            cnt_nx = cnt + CW'(1);
          if (acc) begin
            pv_nx  = 1'b1;
            pch_nx = reg_din[2:0];
            pop_nx = reg_din[6:3];
            ovf_nx = pv;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == ACTIVE) || pv_nx;
  end

  always_comb begin
    up_keyon = (state == ACTIVE);
    keyon_ch = ch;
    keyon_op = op;
    kon_busy = busy;
    kon_ovf  = ovf;
  end

endmodule

// File: tb/tb_jt51_kon_wr.sv
// tb/tb_jt51_kon_wr.sv - directed self-checking bench for jt51_kon_wr
module tb_jt51_kon_wr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b1;
  logic       reg_wr = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_din = 8'h00;
  logic       up_keyon;
  logic [2:0] keyon_ch;
  logic [3:0] keyon_op;
  logic       kon_busy;
  logic       kon_ovf;

  int checks = 0;
  int failures = 0;
  int n;
  logic saw_13;
  logic ovf_seen;

  jt51_kon_wr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .reg_wr   (reg_wr),
    .reg_addr (reg_addr),
    .reg_din  (reg_din),
    .up_keyon (up_keyon),
    .keyon_ch (keyon_ch),
    .keyon_op (keyon_op),
    .kon_busy (kon_busy),
    .kon_ovf  (kon_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] din);
    reg_wr   = 1'b1;
    reg_addr = addr;
    reg_din  = din;
    tick();
    reg_wr   = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_up", up_keyon, 0);
    chk("rst_ch", keyon_ch, 0);
    chk("rst_op", keyon_op, 0);
    chk("rst_busy", kon_busy, 0);
    chk("rst_ovf", kon_ovf, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single request, cen always high
    wr(8'h08, 8'h7A);
    chk("t1_up", up_keyon, 1);
    chk("t1_ch", keyon_ch, 2);
    chk("t1_op", keyon_op, 4'hF);
    chk("t1_busy", kon_busy, 1);
    n = 0;
    while (up_keyon && n < 200) begin tick(); n++; end
    chk("t1_len", n, 32);
    chk("t1_busy_end", kon_busy, 0);
    chk("t1_ch_hold", keyon_ch, 2);

    // 2: cen toggling one-of-two
    tick();
    wr(8'h08, 8'h0D);
    chk("t2_ch", keyon_ch, 5);
    chk("t2_op", keyon_op, 1);
    n = 0;
    while (up_keyon && n < 300) begin cen = n[0]; tick(); n++; end
    chk("t2_len", n, 64);
    cen = 1'b1;
    tick();

    // 3: queued second request follows without a gap
    wr(8'h08, 8'h0B);
    chk("t3_ch0", keyon_ch, 3);
    n = 0;
    while (up_keyon && n < 300) begin
      if (n == 10) begin reg_wr = 1'b1; reg_addr = 8'h08; reg_din = 8'h41; end
      else reg_wr = 1'b0;
      tick();
      n++;
      if (n == 11) chk("t3_busy_pend", kon_busy, 1);
      if (n == 31) chk("t3_ch_before", keyon_ch, 3);
      if (n == 32) begin
        chk("t3_up_nogap", up_keyon, 1);
        chk("t3_ch1", keyon_ch, 1);
        chk("t3_op1", keyon_op, 8);
      end
    end
    reg_wr = 1'b0;
    chk("t3_len", n, 64);
    chk("t3_busy_end", kon_busy, 0);
    tick();

    // 4: pending overwrite, last write wins
    wr(8'h08, 8'h7A);
    tick(); tick(); tick();
    wr(8'h08, 8'h13);
    chk("t4_ovf_first", kon_ovf, 0);
    tick(); tick();
    wr(8'h08, 8'h21);
    chk("t4_ovf_pulse", kon_ovf, 1);
    tick();
    chk("t4_ovf_clear", kon_ovf, 0);
    saw_13 = 1'b0;
    ovf_seen = 1'b0;
    n = 0;
    while (up_keyon && keyon_ch == 3'd2 && n < 100) begin tick(); n++; end
    chk("t4_ch", keyon_ch, 1);
    chk("t4_op", keyon_op, 4);
    n = 0;
    while (up_keyon && n < 100) begin
      if (keyon_ch == 3'd3) saw_13 = 1'b1;
      if (kon_ovf) ovf_seen = 1'b1;
      tick();
      n++;
    end
    chk("t4_len2", n, 32);
    chk("t4_no_13", saw_13, 0);
    chk("t4_ovf_once", ovf_seen, 0);
    tick();

    // 5: foreign addresses ignored, then write on the completion edge
    wr(8'h09, 8'h7A);
    chk("t5_up_09", up_keyon, 0);
    wr(8'h20, 8'h7A);
    chk("t5_up_20", up_keyon, 0);
    chk("t5_busy", kon_busy, 0);
    tick();
    chk("t5_up_idle", up_keyon, 0);
    wr(8'h08, 8'h7A);
    for (int i = 0; i < 31; i++) tick();
    chk("t5_up_pre", up_keyon, 1);
    wr(8'h08, 8'h0D);
    chk("t5_up_edge", up_keyon, 1);
    chk("t5_ch", keyon_ch, 5);
    chk("t5_op", keyon_op, 1);
    chk("t5_ovf", kon_ovf, 0);
    n = 0;
    while (up_keyon && n < 100) begin tick(); n++; end
    chk("t5_len", n, 32);
    tick();

    // 6: asynchronous reset with a pending request
    wr(8'h08, 8'h7A);
    for (int i = 0; i < 4; i++) tick();
    wr(8'h08, 8'h13);
    for (int i = 0; i < 10; i++) tick();
    chk("t6_busy_pre", kon_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_up", up_keyon, 0);
    chk("t6_ch", keyon_ch, 0);
    chk("t6_op", keyon_op, 0);
    chk("t6_busy", kon_busy, 0);
    chk("t6_ovf", kon_ovf, 0);
    tick();
    rst_n = 1'b1;
    saw_13 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (up_keyon || kon_busy) saw_13 = 1'b1;
    end
    chk("t6_quiet", saw_13, 0);
    wr(8'h08, 8'h0D);
    chk("t6_new_up", up_keyon, 1);
    chk("t6_new_ch", keyon_ch, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
